// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the fetch-stage state encoding.
// Imported by the fetch stage and the control-unit decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // Branch displacement: word offset sign-extended and converted to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selector for the fetch stage: sequential, taken
// beq/bne, j/jal and jr, with a misaligned flag for a bad jr target.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] pc4;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        is_branch;
    logic        is_jump;
    logic        is_jr;

    assign pc4       = pc + 32'd4;
    assign op        = instr[31:26];
    assign fn        = instr[5:0];
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_jump   = (op == OP_J) || (op == OP_JAL);
    assign is_jr     = (op == OP_RTYPE) && (fn == FUNCT_JR);

    // Priority order matters: a taken branch wins, then jumps, then jr.
    always_comb begin
        target     = pc4;
        misaligned = 1'b0;
        if (is_branch && branch_taken) begin
            target = pc4 + branch_offset(instr[15:0]);
        end else if (is_jump) begin
            target = jump_target(pc4, instr[25:0]);
        end else if (is_jr) begin
            target     = jr_target;
            misaligned = |jr_target[1:0];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per req/ready
// handshake and presents it to the decoder until the datapath advances.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic        instrValid,
    input  logic        advance,
    input  logic        branchTaken,
    input  logic [31:0] jrTarget,
    output logic        fault
);

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;

    logic [31:0]  target;
    logic         misaligned;

    next_pc u_next_pc (
        .pc           (pc_q),
        .instr        (instr_q),
        .branch_taken (branchTaken),
        .jr_target    (jrTarget),
        .target       (target),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC_W;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imemReady) begin
                    instr_d = imemData;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A misaligned jr parks the stage with pc still on the jr.
                if (advance) begin
                    if (misaligned) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = target;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imemReq    = (state_q == ST_FETCH);
    assign imemAddr   = {pc_q[31:2], 2'b00};
    assign instrValid = (state_q == ST_HOLD);
    assign fault      = (state_q == ST_FAULT);
    assign instr      = instr_q;
    assign opcode     = instr_q[31:26];
    assign funct      = instr_q[5:0];
    assign pc         = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized instruction streams checked against a next-PC reference model.
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemData = 32'd0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        instrValid;
    logic        advance = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] jrTarget = 32'd0;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemData    (imemData),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .pc          (pc),
        .instrValid  (instrValid),
        .advance     (advance),
        .branchTaken (branchTaken),
        .jrTarget    (jrTarget),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic bt, input logic [31:0] jr,
                                             output logic bad);
        int          op;
        int          fn;
        int          off;
        logic [31:0] seq;
        op  = int'(w[31:26]);
        fn  = int'(w[5:0]);
        seq = p + 32'd4;
        bad = 1'b0;
        if ((op == 4 || op == 5) && bt) begin
            off = int'($signed(w[15:0])) * 4;
            return seq + off;
        end
        if (op == 2 || op == 3)
            return (seq & 32'hF000_0000) | (32'(w[25:0]) * 4);
        if (op == 0 && fn == 8) begin
            bad = (jr % 4) != 0;
            return bad ? p : jr;
        end
        return seq;
    endfunction

    // Entered at a FETCH sample point; leaves at the first HOLD sample point.
    task automatic fetch(input string tag, input logic [31:0] w, input int waits,
                         input logic [31:0] exp_addr);
        chk({tag, ".req"}, 32'(imemReq), 32'd1);
        chk({tag, ".addr"}, imemAddr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            imemReady = 1'b0;
            step();
            chk({tag, ".wait_req"}, 32'(imemReq), 32'd1);
            chk({tag, ".wait_addr"}, imemAddr, exp_addr);
            chk({tag, ".wait_valid"}, 32'(instrValid), 32'd0);
        end
        imemReady = 1'b1;
        imemData  = w;
        step();
        imemReady = 1'b0;
        imemData  = $urandom();
        chk({tag, ".valid"}, 32'(instrValid), 32'd1);
        chk({tag, ".hold_req"}, 32'(imemReq), 32'd0);
        chk({tag, ".instr"}, instr, w);
        chk({tag, ".opcode"}, 32'(opcode), 32'(w[31:26]));
        chk({tag, ".funct"}, 32'(funct), 32'(w[5:0]));
        chk({tag, ".pc"}, pc, exp_addr);
    endtask

    task automatic adv(input logic bt, input logic [31:0] jr);
        advance     = 1'b1;
        branchTaken = bt;
        jrTarget    = jr;
        step();
        advance     = 1'b0;
        branchTaken = 1'($urandom_range(0, 1));
        jrTarget    = $urandom();
    endtask

    task automatic goto_pc(input logic [31:0] cur, input logic [31:0] tgt);
        fetch("goto", 32'h0000_0008, 0, cur);
        adv(1'b0, tgt);
        chk("goto.addr", imemAddr, tgt);
    endtask

    // Leaves at the first FETCH sample point after reset release.
    task automatic do_reset();
        rst_n     = 1'b0;
        advance   = 1'b0;
        imemReady = 1'b0;
        step();
        chk("rst.req", 32'(imemReq), 32'd0);
        chk("rst.valid", 32'(instrValid), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.pc", pc, RPC);
        chk("rst.instr", instr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle.req", 32'(imemReq), 32'd0);
        step();
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] w;
        logic [31:0] nxt;
        logic [31:0] jr;
        logic        bt;
        logic        bad;
        int          waits;

        step();
        do_reset();

        // First fetch and decoded fields.
        fetch("first", 32'h2008_0005, 0, RPC);
        chk("first.opcode8", 32'(opcode), 32'd8);
        chk("first.funct5", 32'(funct), 32'd5);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold.valid", 32'(instrValid), 32'd1);
            chk("hold.pc", pc, RPC);
            chk("hold.req", 32'(imemReq), 32'd0);
        end
        adv(1'b0, 32'd0);
        chk("seq.addr", imemAddr, 32'h0040_0004);

        // Branches.
        goto_pc(32'h0040_0004, 32'h100);
        fetch("beq_t", 32'h1000_FFFF, 0, 32'h100);
        adv(1'b1, 32'd0);
        chk("beq_t.next", imemAddr, 32'h100);
        fetch("beq_n", 32'h1000_FFFF, 1, 32'h100);
        adv(1'b0, 32'd0);
        chk("beq_n.next", imemAddr, 32'h104);
        goto_pc(32'h104, 32'h100);
        fetch("bne_t", 32'h1400_0004, 0, 32'h100);
        adv(1'b1, 32'd0);
        chk("bne_t.next", imemAddr, 32'h114);

        // Jumps.
        goto_pc(32'h114, 32'h3000_0010);
        fetch("j", 32'h0800_0040, 0, 32'h3000_0010);
        adv(1'b0, 32'd0);
        chk("j.next", imemAddr, 32'h3000_0100);
        goto_pc(32'h3000_0100, 32'h3000_0010);
        fetch("jal", 32'h0C00_0040, 0, 32'h3000_0010);
        adv(1'b1, 32'd0);
        chk("jal.next", imemAddr, 32'h3000_0100);

        // jr aligned then misaligned.
        fetch("jr", 32'h0000_0008, 0, 32'h3000_0100);
        adv(1'b0, 32'h200);
        chk("jr.next", imemAddr, 32'h200);
        fetch("jr_bad", 32'h0000_0008, 0, 32'h200);
        adv(1'b0, 32'h202);
        for (int i = 0; i < 10; i++) begin
            chk("fault.flag", 32'(fault), 32'd1);
            chk("fault.req", 32'(imemReq), 32'd0);
            chk("fault.valid", 32'(instrValid), 32'd0);
            chk("fault.pc", pc, 32'h200);
            imemReady = 1'($urandom_range(0, 1));
            advance   = 1'($urandom_range(0, 1));
            step();
        end
        do_reset();

        // Wait states.
        fetch("wait3", 32'h2008_0005, 3, RPC);
        adv(1'b0, 32'd0);

        // Asynchronous reset while waiting on memory.
        imemReady = 1'b0;
        step();
        chk("pre_rst.req", 32'(imemReq), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst.req", 32'(imemReq), 32'd0);
        chk("async_rst.pc", pc, RPC);
        imemReady = 1'b1;
        imemData  = 32'h1234_5678;
        step();
        rst_n = 1'b1;
        step();
        imemReady = 1'b0;
        chk("post_rst.req", 32'(imemReq), 32'd1);
        chk("post_rst.addr", imemAddr, RPC);
        chk("post_rst.valid", 32'(instrValid), 32'd0);
        chk("post_rst.instr", instr, 32'd0);
        fetch("after_rst", 32'h2008_0005, 0, RPC);
        adv(1'b0, 32'd0);

        // Address wrap; branchTaken has no effect on addi.
        goto_pc(32'h0040_0004, 32'hFFFF_FFFC);
        fetch("wrap", 32'h2008_0005, 0, 32'hFFFF_FFFC);
        adv(1'b1, 32'd0);
        chk("wrap.next", imemAddr, 32'h0000_0000);

        // Randomized instruction stream.
        cur = 32'h0;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: w = {6'd0, 20'($urandom()), 6'd8};
                1: w = {6'd0, 20'($urandom()), 6'($urandom_range(9, 63))};
                2: w = {6'd2, 26'($urandom())};
                3: w = {6'd3, 26'($urandom())};
                4: w = {6'd4, 26'($urandom())};
                5: w = {6'd5, 26'($urandom())};
                default: w = {6'($urandom_range(6, 63)), 26'($urandom())};
            endcase
            waits = $urandom_range(0, 2);
            fetch("rnd", w, waits, cur);
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                branchTaken = 1'($urandom_range(0, 1));
                jrTarget    = $urandom();
                step();
                chk("rnd.hold_valid", 32'(instrValid), 32'd1);
                chk("rnd.hold_pc", pc, cur);
            end
            bt = 1'($urandom_range(0, 1));
            jr = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            nxt = ref_next(cur, w, bt, jr, bad);
            adv(bt, jr);
            if (bad) begin
                chk("rnd.fault", 32'(fault), 32'd1);
                chk("rnd.fault_req", 32'(imemReq), 32'd0);
                chk("rnd.fault_pc", pc, cur);
                do_reset();
                cur = RPC;
            end else begin
                chk("rnd.req", 32'(imemReq), 32'd1);
                chk("rnd.next", imemAddr, nxt);
                chk("rnd.nofault", 32'(fault), 32'd0);
                cur = nxt;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Fetch stage that produces the instruction word, and its `opcode`/`funct` fields, for the control-unit decoder.
- Holds the PC and fetches one word at a time from instruction memory over a req/ready handshake.
- Presents the word until the datapath signals completion, then computes the next PC.
- Next PC covers sequential, `beq`/`bne`, `j`/`jal` and `jr` redirection.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imemReq`  out  1  fetch request to instruction memory.
- `imemAddr`  out  32  byte address of the requested word (bits [1:0] always 0).
- `imemReady`  in  1  memory returns `imemData` this cycle.
- `imemData`  in  32  instruction word.
- `instr`  out  32  held instruction register.
- `opcode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc`  out  32  address of the held instruction.
- `instrValid`  out  1  `instr` is valid and awaiting `advance`.
- `advance`  in  1  datapath finished the held instruction; sampled only while `instrValid`=1.
- `branchTaken`  in  1  branch condition result for the held `beq`/`bne`; ignored for other opcodes.
- `jrTarget`  in  32  rs register value for a held `jr`.
- `fault`  out  1  sticky misaligned-`jr` indicator.

## Operation

- States: IDLE, FETCH, HOLD, FAULT.
- Reset values:
  - State IDLE, `pc`=`RESET_PC`, `instr`=0 (decodes as sll nop).
  - `instrValid`=0, `imemReq`=0, `fault`=0.
- IDLE:
  - Outputs quiet; `imemData`/`imemReady` ignored.
  - Next cycle goes to FETCH.
- FETCH:
  - `imemReq`=1, `imemAddr`=`pc`.
  - On `imemReady`=1, `imemData` is captured into `instr`; next state is HOLD.
  - Otherwise stays in FETCH with address stable.
- HOLD:
  - `instrValid`=1, `imemReq`=0.
  - On `advance`=1, `pc` is loaded with next PC and state goes to FETCH.
  - Otherwise holds all outputs.
- Next PC; `pc4` = `pc`+4, 32-bit wrapping; first match wins:
  - opcode 4/5 with `branchTaken`=1: `pc4` + (sign-extended `instr[15:0]` << 2), 32-bit wrap.
  - opcode 2/3: {`pc4[31:28]`, `instr[25:0]`, 2'b00}.
  - opcode 0 with funct 8: `jrTarget`. If `jrTarget[1:0]`≠0, go to FAULT instead; `pc` is unchanged.
  - Otherwise: `pc4`. 0xFFFF_FFFC wraps to 0.
- FAULT:
  - `fault`=1, `imemReq`=0, `instrValid`=0.
  - Left only by reset.
- Reset mid-operation: `rst_n` low forces IDLE and all reset values immediately, without waiting for a clock edge. An `imemReady` arriving after that is ignored.

## Timing

- IDLE lasts exactly 1 cycle after reset release.
- Fetch latency: `instrValid` rises the cycle after the first `imemReady`=1 in FETCH.
- Zero-wait memory with `advance` tied high gives 2 cycles per instruction: FETCH, HOLD.
- `advance` and `branchTaken`/`jrTarget` are sampled in the same HOLD cycle. The datapath must present the branch and jump inputs no later than `advance`.
- `opcode`/`funct`/`instr`/`pc` are registered and change only on the FETCH→HOLD edge (`instr`) or the HOLD→FETCH edge (`pc`).

## Structure

- Shared package `mips_pkg`:
  - Opcode constants `OP_RTYPE`=0, `OP_J`=2, `OP_JAL`=3, `OP_BEQ`=4, `OP_BNE`=5.
  - Funct constant `FUNCT_JR`=8.
  - Fetch state enum.
  - The control unit uses the same constants.
- Sub-module `next_pc`: purely combinational selector from `pc`, `instr`, `branchTaken`, `jrTarget` to {target, misaligned}. `instr_fetch` keeps the FSM and registers.

## Test plan

- Reset with `RESET_PC`=0x0040_0000, zero-wait memory returning 0x2008_0005:
  - `imemAddr`=0x0040_0000 on the 2nd cycle after reset release.
  - Next cycle `instrValid`=1, `opcode`=8, `funct`=5.
  - `advance` → next `imemAddr`=0x0040_0004.
- `beq` (0x1000_FFFF) at `pc`=0x100:
  - `branchTaken`=1 → next fetch 0x100.
  - Repeated with `branchTaken`=0 → 0x104.
  - `bne` with imm 0x0004 taken → 0x114.
- `j` with index 0x000_0040 at `pc`=0x3000_0010 → next fetch 0x3000_0100.
  - `jal` behaves identically.
- `jr` (0x0000_0008):
  - `jrTarget`=0x200 → fetch 0x200.
  - `jrTarget`=0x202 → `fault`=1, `imemReq` stays 0 for 10 cycles, `pc` stays at the `jr` address.
- Wait states:
  - `imemReady` low for 3 cycles → `imemReq`=1 and `imemAddr` stable for 4 cycles, `instrValid`=0.
  - Reset pulsed during the wait → `imemReq` drops without a clock edge.
  - A subsequent `imemReady` is ignored and fetch restarts at `RESET_PC`.
- Wrap: non-branch at `pc`=0xFFFF_FFFC, `advance` → next fetch 0x0000_0000.
  - `branchTaken`=1 on an `addi` has no effect.
